vram_brush_painter: RTL and testbench

// - Multi-channel VRAM write controller for the etch-a-sketch display path.
// - Clears VRAM, then paints a square brush (dab) around each valid touch point.
// - Touch channels are served round-robin; each channel has its own colour.
// - Drives the write port of the block_ram VRAM. The display controller owns the read port.

---
 rtl/vram_brush_painter.sv | 189 ++++++++++++++++++
 tb/tb_vram_brush_painter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_brush_painter.sv
// VRAM write controller: clears the frame buffer, then stamps a square brush
// around each fresh touch point, serving touch channels round-robin.
module vram_brush_painter #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int VRAM_W         = 16,
    parameter int N_CH           = 2,
    parameter int BRUSH          = 3,
    parameter logic [VRAM_W-1:0] CLEAR_COLOR = '0
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               clear_req,
    input  logic [N_CH-1:0]                                    touch_valid,
    input  logic [N_CH*9-1:0]                                  touch_x,
    input  logic [N_CH*9-1:0]                                  touch_y,
    input  logic [N_CH*VRAM_W-1:0]                             ch_color,
    output logic                                               vram_wr_ena,
    output logic [$clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)-1:0]    vram_wr_addr,
    output logic [VRAM_W-1:0]                                  vram_wr_data,
    output logic                                               busy,
    output logic                                               clearing
);

    localparam int NPIX   = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int R      = (BRUSH - 1) / 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(DISPLAY_WIDTH);
    localparam logic signed [10:0] W_S      = 11'(DISPLAY_WIDTH);
    localparam logic signed [10:0] H_S      = 11'(DISPLAY_HEIGHT);
    localparam logic signed [3:0]  R_S      = 4'(R);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_PAINT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] clr_cnt;
    logic [CH_W-1:0]   rr, pick, cur_ch;
    logic              found;
    logic [N_CH-1:0]   eligible;
    logic [8:0]        lat_x, lat_y;
    logic [VRAM_W-1:0] lat_color;
    logic signed [3:0] off_x, off_y;
    logic              clear_pend;
    logic [N_CH-1:0]   ded_valid;
    logic [8:0]        ded_x [N_CH];
    logic [8:0]        ded_y [N_CH];

    logic signed [10:0] px, py;
    logic               pix_on, dab_last;
    logic [ADDR_W-1:0]  pix_addr;

    // A channel is eligible only for an on-screen point that moved since its last dab.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            eligible[c] = touch_valid[c]
                && (int'(touch_x[c*9 +: 9]) < DISPLAY_WIDTH)
                && (int'(touch_y[c*9 +: 9]) < DISPLAY_HEIGHT)
                && !(ded_valid[c] && (ded_x[c] == touch_x[c*9 +: 9])
                                  && (ded_y[c] == touch_y[c*9 +: 9]));
        end
    end

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(rr) + i) % N_CH;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
    end

    // 11-bit signed pixel coordinates so edge pixels clip instead of wrapping.
    assign px       = {2'b00, lat_x} + {{7{off_x[3]}}, off_x};
    assign py       = {2'b00, lat_y} + {{7{off_y[3]}}, off_y};
    assign pix_on   = (px >= 11'sd0) && (px < W_S) && (py >= 11'sd0) && (py < H_S);
    assign pix_addr = ADDR_W'(py[9:0]) * W_A + ADDR_W'(px[9:0]);
    assign dab_last = (off_x == R_S) && (off_y == R_S);

    always_ff @(posedge clk) begin
        if (rst) state <= S_CLEAR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_CLEAR: if (clr_cnt == LAST_ADDR) state_next = S_IDLE;
            S_IDLE: begin
                if (clear_req)  state_next = S_CLEAR;
                else if (found) state_next = S_PAINT;
            end
            S_PAINT: if (dab_last) state_next = (clear_pend || clear_req) ? S_CLEAR : S_IDLE;
            default: state_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt      <= '0;
            rr           <= '0;
            cur_ch       <= '0;
            lat_x        <= '0;
            lat_y        <= '0;
            lat_color    <= '0;
            off_x        <= '0;
            off_y        <= '0;
            clear_pend   <= 1'b0;
            ded_valid    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                ded_x[c] <= '0;
                ded_y[c] <= '0;
            end
            vram_wr_ena  <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= '0;
            busy         <= 1'b1;
            clearing     <= 1'b1;
        end else begin
            vram_wr_ena <= 1'b0;
            busy        <= (state_next != S_IDLE);
            clearing    <= (state_next == S_CLEAR);
            case (state)
                S_CLEAR: begin
                    vram_wr_ena  <= 1'b1;
                    vram_wr_addr <= clr_cnt;
                    vram_wr_data <= CLEAR_COLOR;
                    clr_cnt      <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + 1'b1;
                end
                S_IDLE: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (!touch_valid[c]) ded_valid[c] <= 1'b0;
                    end
                    if (clear_req) begin
                        clr_cnt   <= '0;
                        ded_valid <= '0;
                    end else if (found) begin
                        cur_ch     <= pick;
                        lat_x      <= touch_x[int'(pick)*9 +: 9];
                        lat_y      <= touch_y[int'(pick)*9 +: 9];
                        lat_color  <= ch_color[int'(pick)*VRAM_W +: VRAM_W];
                        rr         <= (int'(pick) == N_CH - 1) ? '0 : pick + 1'b1;
                        off_x      <= -R_S;
                        off_y      <= -R_S;
                        clear_pend <= 1'b0;
                    end
                end
                S_PAINT: begin
                    vram_wr_ena  <= pix_on;
                    vram_wr_addr <= pix_addr;
                    vram_wr_data <= lat_color;
                    if (clear_req) clear_pend <= 1'b1;
                    if (off_x == R_S) begin
                        off_x <= -R_S;
                        off_y <= off_y + 4'sd1;
                    end else begin
                        off_x <= off_x + 4'sd1;
                    end
                    if (dab_last) begin
                        ded_valid[cur_ch] <= 1'b1;
                        ded_x[cur_ch]     <= lat_x;
                        ded_y[cur_ch]     <= lat_y;
                        clear_pend        <= 1'b0;
                        if (clear_pend || clear_req) begin
                            clr_cnt   <= '0;
                            ded_valid <= '0;
                        end
                    end
                end
                default: begin
                    clr_cnt   <= '0;
                    ded_valid <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_brush_painter.sv
// Directed bench for vram_brush_painter: dab vector table plus sequences for
// round-robin, dedup, clear and reset corner cases.
module tb_vram_brush_painter;

    // A shorter screen (same row width) keeps each full clear brief.
    localparam int W    = 240;
    localparam int H    = 64;
    localparam int NPIX = W * H;
    localparam int AW   = $clog2(NPIX);
    localparam logic [16:0] OFF = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            clear_req;
    logic [1:0]      touch_valid;
    logic [17:0]     touch_x;
    logic [17:0]     touch_y;
    logic [31:0]     ch_color;
    logic            vram_wr_ena;
    logic [AW-1:0]   vram_wr_addr;
    logic [15:0]     vram_wr_data;
    logic            busy;
    logic            clearing;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];

    typedef struct packed {
        logic [8:0]         x;
        logic [8:0]         y;
        logic [15:0]        color;
        logic               paints;
        logic [0:8][16:0]   exp_addr;
    } dab_vec_t;

    dab_vec_t vec [6];

    vram_brush_painter #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .VRAM_W        (16),
        .N_CH          (2),
        .BRUSH         (3),
        .CLEAR_COLOR   (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear_req   (clear_req),
        .touch_valid (touch_valid),
        .touch_x     (touch_x),
        .touch_y     (touch_y),
        .ch_color    (ch_color),
        .vram_wr_ena (vram_wr_ena),
        .vram_wr_addr(vram_wr_addr),
        .vram_wr_data(vram_wr_data),
        .busy        (busy),
        .clearing    (clearing)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int ch, input logic v, input logic [8:0] x,
                                  input logic [8:0] y, input logic [15:0] color);
        touch_valid[ch]       = v;
        touch_x[ch*9 +: 9]    = x;
        touch_y[ch*9 +: 9]    = y;
        ch_color[ch*16 +: 16] = color;
    endtask

    // Reference list of on-screen pixels for a 3x3 dab, in row-major order.
    task automatic push_dab(input int x, input int y, input logic [15:0] color);
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
                    exp_q.push_back({17'((y + dy) * W + (x + dx)), color});
            end
        end
    endtask

    task automatic expect_writes(input int ncyc, input int clr_at, input string name);
        logic [32:0] act_q[$];
        int nbad;
        int first;
        nbad  = 0;
        first = -1;
        for (int k = 0; k < ncyc; k++) begin
            tick();
            if (vram_wr_ena) act_q.push_back({17'(vram_wr_addr), vram_wr_data});
            clear_req = (k == clr_at);
        end
        clear_req = 1'b0;
        check_output({name, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            if (act_q[i] !== exp_q[i]) begin
                if (nbad == 0) first = i;
                nbad++;
            end
        end
        check_output($sformatf("%s_seq(first_bad=%0d)", name, first), nbad, 0);
    endtask

    task automatic check_clear(input string name, input int pulse_at);
        int nbad;
        int first;
        nbad  = 0;
        first = -1;
        for (int i = 0; i < NPIX; i++) begin
            tick();
            clear_req = (i == pulse_at);
            if (!(vram_wr_ena === 1'b1 && vram_wr_addr === AW'(i) && vram_wr_data === 16'h0)) begin
                if (nbad == 0) first = i;
                nbad++;
            end
        end
        clear_req = 1'b0;
        check_output($sformatf("%s(first_bad=%0d)", name, first), nbad, 0);
    endtask

    initial begin
        int rm_addr [4];
        int nbad;

        vec[0] = '{x: 9'd100, y: 9'd50, color: 16'hF800, paints: 1'b1,
                   exp_addr: {17'd11859, 17'd11860, 17'd11861, 17'd12099, 17'd12100,
                              17'd12101, 17'd12339, 17'd12340, 17'd12341}};
        vec[1] = '{x: 9'd0, y: 9'd0, color: 16'h07E0, paints: 1'b1,
                   exp_addr: {OFF, OFF, OFF, OFF, 17'd0, 17'd1, OFF, 17'd240, 17'd241}};
        vec[2] = '{x: 9'd239, y: 9'd63, color: 16'h001F, paints: 1'b1,
                   exp_addr: {17'd15118, 17'd15119, OFF, 17'd15358, 17'd15359, OFF,
                              OFF, OFF, OFF}};
        vec[3] = '{x: 9'd240, y: 9'd10, color: 16'hFFFF, paints: 1'b0,
                   exp_addr: {OFF, OFF, OFF, OFF, OFF, OFF, OFF, OFF, OFF}};
        vec[4] = '{x: 9'd5, y: 9'd64, color: 16'hFFFF, paints: 1'b0,
                   exp_addr: {OFF, OFF, OFF, OFF, OFF, OFF, OFF, OFF, OFF}};
        vec[5] = '{x: 9'd239, y: 9'd0, color: 16'hABCD, paints: 1'b1,
                   exp_addr: {OFF, OFF, OFF, 17'd238, 17'd239, OFF, 17'd478, 17'd479, OFF}};
        rm_addr = '{4619, 4620, 4621, 4859};

        rst         = 1'b1;
        clear_req   = 1'b0;
        touch_valid = '0;
        touch_x     = '0;
        touch_y     = '0;
        ch_color    = '0;

        repeat (4) tick();
        check_output("rst_ena", vram_wr_ena, 1'b0);
        check_output("rst_addr", vram_wr_addr, '0);
        check_output("rst_data", vram_wr_data, 16'h0);
        check_output("rst_busy", busy, 1'b1);
        check_output("rst_clearing", clearing, 1'b1);
        rst = 1'b0;
        check_clear("init_clear", -1);
        tick();
        check_output("post_init_flags", {busy, clearing, vram_wr_ena}, 3'b000);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 1'b1, vec[i].x, vec[i].y, vec[i].color);
            tick();
            check_output($sformatf("v%0d_busy", i), busy, vec[i].paints);
            for (int k = 0; k < 9; k++) begin
                tick();
                if (vec[i].exp_addr[k] == OFF)
                    check_output($sformatf("v%0d_k%0d_off", i, k), vram_wr_ena, 1'b0);
                else
                    check_output($sformatf("v%0d_k%0d_pix", i, k),
                                 {vram_wr_ena, 17'(vram_wr_addr), vram_wr_data},
                                 {1'b1, vec[i].exp_addr[k], vec[i].color});
            end
            apply_stimulus(0, 1'b0, 9'd0, 9'd0, 16'h0);
            tick();
            check_output($sformatf("v%0d_idle", i), {busy, vram_wr_ena}, 2'b00);
        end

        exp_q.delete();
        push_dab(200, 5, 16'h0F0F);
        apply_stimulus(1, 1'b1, 9'd200, 9'd5, 16'h0F0F);
        expect_writes(11, -1, "ch1_solo");
        apply_stimulus(1, 1'b0, 9'd0, 9'd0, 16'h0);
        tick();

        exp_q.delete();
        push_dab(10, 10, 16'h1111);
        push_dab(20, 20, 16'h2222);
        apply_stimulus(0, 1'b1, 9'd10, 9'd10, 16'h1111);
        apply_stimulus(1, 1'b1, 9'd20, 9'd20, 16'h2222);
        expect_writes(24, -1, "rr_both");
        apply_stimulus(0, 1'b0, 9'd10, 9'd10, 16'h1111);
        tick();
        check_output("rr_drop_idle", {busy, vram_wr_ena}, 2'b00);
        exp_q.delete();
        push_dab(10, 10, 16'h1111);
        apply_stimulus(0, 1'b1, 9'd10, 9'd10, 16'h1111);
        expect_writes(12, -1, "rr_return");
        apply_stimulus(0, 1'b0, 9'd0, 9'd0, 16'h0);
        apply_stimulus(1, 1'b0, 9'd0, 9'd0, 16'h0);
        tick();

        exp_q.delete();
        push_dab(30, 30, 16'h7777);
        apply_stimulus(0, 1'b1, 9'd30, 9'd30, 16'h7777);
        expect_writes(10, 2, "clr_in_paint");
        apply_stimulus(0, 1'b0, 9'd0, 9'd0, 16'h0);
        check_clear("clear_after_dab", -1);
        tick();
        check_output("post_clear2_flags", {busy, clearing, vram_wr_ena}, 3'b000);

        apply_stimulus(0, 1'b1, 9'd70, 9'd40, 16'h1234);
        clear_req = 1'b1;
        tick();
        check_output("clear_wins_flags", {busy, clearing, vram_wr_ena}, 3'b110);
        clear_req = 1'b0;
        apply_stimulus(0, 1'b0, 9'd0, 9'd0, 16'h0);
        check_clear("clear_wins_noretrig", 100);
        tick();
        check_output("post_clear3_flags", {busy, clearing, vram_wr_ena}, 3'b000);

        apply_stimulus(0, 1'b1, 9'd60, 9'd20, 16'h5555);
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check_output($sformatf("rstdab_k%0d", k),
                         {vram_wr_ena, 17'(vram_wr_addr), vram_wr_data},
                         {1'b1, 17'(rm_addr[k]), 16'h5555});
        end
        rst = 1'b1;
        apply_stimulus(0, 1'b0, 9'd0, 9'd0, 16'h0);
        tick();
        check_output("rstdab_abort", {vram_wr_ena, busy, clearing}, 3'b011);
        tick();
        rst = 1'b0;
        nbad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(vram_wr_ena === 1'b1 && vram_wr_addr === AW'(i) && vram_wr_data === 16'h0))
                nbad++;
        end
        check_output("rstdab_restart", nbad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
